// File: rtl/rv32i_pkg.sv
// Shared RV32I branch definitions.
// Holds the branch funct3 codes, the resolution sequencer state encoding and
// two small helpers that classify a funct3 and turn (eq, lt) into a taken bit.
// No ports: package only.
package rv32i_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } br_state_e;

  // funct3 010 and 011 have no branch meaning in RV32I.
  function automatic logic brIsIllegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

  // Maps the comparison result onto the branch condition; illegal codes never take.
  function automatic logic brDecide(input logic [2:0] f3, input logic eq, input logic lt);
    logic taken;
    taken = 1'b0;
    case (f3)
      BR_BEQ:           taken = eq;
      BR_BNE:           taken = !eq;
      BR_BLT, BR_BLTU:  taken = lt;
      BR_BGE, BR_BGEU:  taken = !lt;
      default:          taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_slice_cmp.sv
// Combinational unsigned magnitude comparator for one operand slice.
// Ports:
//   i_a, i_b  W-bit slices to compare
//   o_eq      i_a == i_b
//   o_lt      i_a <  i_b (unsigned)
module branch_slice_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq,
  output logic         o_lt
);

  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a <  i_b);

endmodule

// File: rtl/branch_resolve_seq.sv
// Multi-cycle branch resolution sequencer.
// A single SLICE_W-bit comparator walks rs1/rs2 from the most significant
// slice down and stops at the first slice that differs, then the branch
// condition and next PC are registered out with a one-cycle done pulse.
// XLEN must be a multiple of SLICE_W.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_start, i_flush         request pulse (IDLE only), pipeline kill
//   i_funct3                 branch funct3
//   i_rs1_data, i_rs2_data   operands A and B
//   i_pc, i_imm              branch PC and sign-extended B-type offset
//   o_busy                   sequencer in CMP or DONE
//   o_done                   one-cycle pulse, results valid
//   o_br_eq, o_br_lt         comparison results (signedness per funct3)
//   o_taken, o_illegal       branch decision, unsupported funct3 flag
//   o_next_pc                taken ? pc+imm : pc+4 (wraps)
module branch_resolve_seq
  import rv32i_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_br_eq,
  output logic            o_br_lt,
  output logic            o_taken,
  output logic            o_illegal,
  output logic [XLEN-1:0] o_next_pc
);

  localparam int NSLICE = XLEN / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

  br_state_e         r_state;
  br_state_e         w_nextState;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_imm;
  logic [2:0]        r_funct3;
  logic [IDX_W-1:0]  r_idx;
  logic              r_cmpEq;
  logic              r_cmpLt;

  logic [XLEN-1:0]   w_signFlip;
  logic [SLICE_W-1:0] w_sliceA;
  logic [SLICE_W-1:0] w_sliceB;
  logic              w_sliceEq;
  logic              w_sliceLt;
  logic              w_accept;
  logic              w_illegal;
  logic              w_taken;
  logic [XLEN-1:0]   w_nextPc;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so one unsigned slice scan serves every branch type.
  assign w_signFlip = {~i_funct3[1], {(XLEN-1){1'b0}}};

  assign w_sliceA = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_sliceB = r_b[r_idx*SLICE_W +: SLICE_W];

  branch_slice_cmp #(.W(SLICE_W)) u_sliceCmp (
    .i_a  (w_sliceA),
    .i_b  (w_sliceB),
    .o_eq (w_sliceEq),
    .o_lt (w_sliceLt)
  );

  // flush in IDLE drops a coincident request.
  assign w_accept  = (r_state == IDLE) && i_start && !i_flush;
  assign w_illegal = brIsIllegal(r_funct3);
  assign w_taken   = !w_illegal && brDecide(r_funct3, r_cmpEq, r_cmpLt);
  assign w_nextPc  = w_taken ? (r_pc + r_imm) : (r_pc + XLEN'(4));
  assign o_busy    = (r_state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Scan ends on the first unequal slice or after slice 0; flush beats
  // every other transition out of CMP and DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = brIsIllegal(i_funct3) ? DONE : CMP;
        end
      end
      CMP: begin
        if (i_flush) begin
          w_nextState = IDLE;
        end else if (!w_sliceEq || (r_idx == '0)) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Comparison results are kept internally until DONE so that a flush in
  // DONE leaves the visible outputs from the previous branch untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_pc      <= '0;
      r_imm     <= '0;
      r_funct3  <= '0;
      r_idx     <= IDX_TOP;
      r_cmpEq   <= 1'b0;
      r_cmpLt   <= 1'b0;
      o_done    <= 1'b0;
      o_br_eq   <= 1'b0;
      o_br_lt   <= 1'b0;
      o_taken   <= 1'b0;
      o_illegal <= 1'b0;
      o_next_pc <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a      <= i_rs1_data ^ w_signFlip;
            r_b      <= i_rs2_data ^ w_signFlip;
            r_pc     <= i_pc;
            r_imm    <= i_imm;
            r_funct3 <= i_funct3;
            r_idx    <= IDX_TOP;
            r_cmpEq  <= 1'b0;
            r_cmpLt  <= 1'b0;
          end
        end
        CMP: begin
          if (i_flush) begin
            r_idx <= IDX_TOP;
          end else if (!w_sliceEq) begin
            r_cmpEq <= 1'b0;
            r_cmpLt <= w_sliceLt;
          end else if (r_idx == '0) begin
            r_cmpEq <= 1'b1;
            r_cmpLt <= 1'b0;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        DONE: begin
          r_idx <= IDX_TOP;
          if (!i_flush) begin
            o_done    <= 1'b1;
            o_br_eq   <= r_cmpEq & ~w_illegal;
            o_br_lt   <= r_cmpLt & ~w_illegal;
            o_taken   <= w_taken;
            o_illegal <= w_illegal;
            o_next_pc <= w_nextPc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_seq.sv
// Scoreboard bench for branch_resolve_seq: each accepted request pushes its
// expected result (including the cycle its done pulse must appear) and an
// independent monitor pops and compares on every done pulse.
module tb_branch_resolve_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        busy;
  logic        done;
  logic        brEq;
  logic        brLt;
  logic        taken;
  logic        illegal;
  logic [31:0] nextPc;

  typedef struct {
    logic        eq;
    logic        lt;
    logic        taken;
    logic        illegal;
    logic [31:0] nextPc;
    int          doneCycle;
  } exp_t;

  exp_t expQ[$];
  exp_t lastExp;
  int   cycleCnt  = 0;
  int   testCount = 0;
  int   failCount = 0;

  branch_resolve_seq #(.XLEN(32), .SLICE_W(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_flush    (flush),
    .i_funct3   (funct3),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_pc       (pc),
    .i_imm      (imm),
    .o_busy     (busy),
    .o_done     (done),
    .o_br_eq    (brEq),
    .o_br_lt    (brLt),
    .o_taken    (taken),
    .o_illegal  (illegal),
    .o_next_pc  (nextPc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycleCnt);
    end
  endtask

  // Reference: plain signed/unsigned compares; latency from the highest
  // differing bit (slices inspected = 8 - its nibble index).
  function automatic exp_t refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] p, input logic [31:0] im);
    exp_t        e;
    logic [31:0] d;
    int          k;
    e.illegal = (f3 == 3'b010) || (f3 == 3'b011);
    if (e.illegal) begin
      e.eq = 1'b0;
      e.lt = 1'b0;
      e.taken = 1'b0;
      e.doneCycle = 1;
    end else begin
      e.eq = (a == b);
      e.lt = f3[1] ? (a < b) : ($signed(a) < $signed(b));
      case (f3)
        3'b000:         e.taken = e.eq;
        3'b001:         e.taken = !e.eq;
        3'b100, 3'b110: e.taken = e.lt;
        default:        e.taken = !e.lt;
      endcase
      d = a ^ b;
      k = 8;
      for (int bp = 31; bp >= 0; bp--) begin
        if (d[bp]) begin
          k = 8 - bp / 4;
          break;
        end
      end
      e.doneCycle = k + 1;
    end
    e.nextPc = e.taken ? (p + im) : (p + 32'd4);
    return e;
  endfunction

  // Must be called at a negedge; returns at a negedge.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] p, input logic [31:0] im);
    exp_t e;
    int   guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("idle_wait_timeout", 32'd1, 32'd0);
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    pc     = p;
    imm    = im;
    start  = 1'b1;
    e = refModel(f3, a, b, p, im);
    e.doneCycle = e.doneCycle + cycleCnt + 1;
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((busy !== 1'b0 || expQ.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("done_cycle", cycleCnt, e.doneCycle);
        checkOutput("br_eq", {31'd0, brEq}, {31'd0, e.eq});
        checkOutput("br_lt", {31'd0, brLt}, {31'd0, e.lt});
        checkOutput("taken", {31'd0, taken}, {31'd0, e.taken});
        checkOutput("illegal", {31'd0, illegal}, {31'd0, e.illegal});
        checkOutput("next_pc", nextPc, e.nextPc);
        lastExp = e;
      end
    end
  end

  initial begin
    exp_t snap;
    lastExp = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0};
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
    rs1 = '0; rs2 = '0; pc = '0; imm = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_flags", {28'd0, brEq, brLt, taken, illegal}, 32'd0);
    checkOutput("rst_next_pc", nextPc, 32'd0);

    applyStimulus(3'b000, 32'h1234_5678, 32'h1234_5678, 32'h0000_1000, 32'h0000_0040);
    applyStimulus(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_2000, 32'hFFFF_FFF0);
    applyStimulus(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_2000, 32'hFFFF_FFF0);
    applyStimulus(3'b111, 32'h0000_0010, 32'h0000_0001, 32'hFFFF_FFFC, 32'h0000_0008);
    applyStimulus(3'b010, 32'h0000_0005, 32'h0000_0005, 32'h0000_3000, 32'h0000_0100);
    applyStimulus(3'b011, 32'h8000_0000, 32'h0000_0005, 32'h0000_3100, 32'h0000_0100);
    waitIdle();

    // Flush mid-scan: start edge = cycle 0, flush sampled at cycle 3.
    snap = lastExp;
    funct3 = 3'b001; rs1 = 32'hAAAA_0000; rs2 = 32'hAAAA_0001;
    pc = 32'h0000_4000; imm = 32'h0000_0020; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    checkOutput("flush_done", {31'd0, done}, 32'd0);
    checkOutput("flush_hold_flags", {28'd0, brEq, brLt, taken, illegal},
                {28'd0, snap.eq, snap.lt, snap.taken, snap.illegal});
    checkOutput("flush_hold_next_pc", nextPc, snap.nextPc);
    applyStimulus(3'b101, 32'h7000_0000, 32'h8000_0000, 32'h0000_5000, 32'h0000_0010);
    waitIdle();

    // flush together with start in IDLE drops the request.
    funct3 = 3'b000; start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    checkOutput("flush_start_busy", {31'd0, busy}, 32'd0);
    waitIdle();

    // start held high through the whole BEQ: exactly one accepted.
    funct3 = 3'b000; rs1 = 32'hCAFE_BABE; rs2 = 32'hCAFE_BABE;
    pc = 32'h0000_6000; imm = 32'h0000_0100; start = 1'b1;
    begin
      exp_t e;
      e = refModel(3'b000, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'h0000_6000, 32'h0000_0100);
      e.doneCycle = e.doneCycle + cycleCnt + 1;
      expQ.push_back(e);
    end
    repeat (10) @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    waitIdle();

    // Reset mid-scan: start edge = cycle 0, rst sampled at cycle 4.
    funct3 = 3'b000; rs1 = 32'h1111_1111; rs2 = 32'h1111_1111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    checkOutput("midrst_flags", {28'd0, brEq, brLt, taken, illegal}, 32'd0);
    checkOutput("midrst_next_pc", nextPc, 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = $urandom;
        2:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = a ^ 32'h8000_0000;
      endcase
      applyStimulus(3'($urandom_range(0, 7)), a, b, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    waitIdle();
    checkOutput("queue_empty", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
